calibration_host: RTL and testbench
===================================

Name: calibration_host

Overview:
- Host-side initiator for frequency_calibrator: accepts a stream of signed frequency deltas, stores them in an internal list memory, and presents list contents and length to the calibrator.
- Runs two calibrations back to back over the enable/ready handshake: a single pass (re_iterate=0) producing the summed frequency, then a repeat search (re_iterate=1) producing the first repeated frequency.
- Captures both results and reports them to the upstream controller.
- Replaces the hand-driven calibration sequence with synthesizable control.

Parameters:
- DATA_W, 20: width of deltas and frequencies (signed, two's complement).
- DEPTH, 1024: list memory entries.
- ADDR_W, 10: list address width; DEPTH = 2**ADDR_W.
- TIMEOUT, 1048576: maximum cycles allowed per calibration run while waiting for ready to rise.

Ports:
- CLK  in  1  Clock; all state changes on the rising edge.
- RST_N  in  1  Asynchronous active-low reset.
- in_valid  in  1  Delta word valid.
- in_ready  out  1  Block can accept a delta.
- in_data  in  DATA_W  Signed delta.
- in_last  in  1  Final delta of the list. Qualified by in_valid & in_ready.
- freq_initial  in  DATA_W  Starting frequency. Sampled on the in_last handshake.
- fc_enable  out  1  Calibration request to the calibrator.
- fc_ready  in  1  Calibrator idle/done.
- fc_re_iterate  out  1  Run mode: 0 = single pass, 1 = repeat search.
- fc_frequency_initial  out  DATA_W  Held copy of freq_initial.
- fc_frequency_result  in  DATA_W  Calibrator result.
- list_rd_addr  in  ADDR_W  Calibrator read address.
- list_rd_data  out  DATA_W  Memory word at list_rd_addr. Registered, 1-cycle latency.
- list_length  out  ADDR_W+1  Number of stored entries, range 0..DEPTH.
- sum_result  out  DATA_W  Result of the single-pass run.
- repeat_result  out  DATA_W  Result of the repeat-search run.
- results_valid  out  1  Both results are valid.
- repeat_timeout  out  1  Repeat run exceeded TIMEOUT; repeat_result is invalid.
- overflow  out  1  More than DEPTH deltas were offered.
- busy  out  1  High in every state except IDLE.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - State goes to IDLE.
  - All outputs 0 except in_ready=1.
  - list_length=0. Memory contents are not cleared.
  - Reset mid-run drops fc_enable immediately. The calibrator sees the request withdrawn.
- States: IDLE, LOAD, REQ1, WAIT1, REQ2, WAIT2.
- IDLE:
  - in_ready=1.
  - The first accepted word writes address 0, sets list_length=1, and clears results_valid, repeat_timeout and overflow.
  - If that word has in_last=1, go to REQ1; otherwise go to LOAD.
- LOAD:
  - in_ready=1.
  - Each accepted word writes at address list_length, then list_length increments.
  - When list_length==DEPTH, further words are accepted and discarded, overflow is set, and list_length stays at DEPTH.
  - An accepted in_last goes to REQ1.
  - On the in_last handshake, freq_initial is captured into fc_frequency_initial and in_ready drops the following cycle.
  - An empty list is impossible, since in_last always carries a word.
- REQ1:
  - fc_re_iterate=0, fc_enable=1.
  - When fc_ready is sampled 0, drop fc_enable and go to WAIT1.
- WAIT1:
  - When fc_ready is sampled 1, capture fc_frequency_result into sum_result and go to REQ2.
- REQ2 / WAIT2: identical to REQ1 / WAIT1 with fc_re_iterate=1.
  - On fc_ready=1, capture repeat_result, set results_valid=1, and go to IDLE.
- fc_re_iterate is held stable from REQ entry until WAIT exit.
- Timeout:
  - A cycle counter resets on entry to REQ1 and REQ2 and counts through the REQ and WAIT states.
  - Reaching TIMEOUT in run 1 or run 2 sets repeat_timeout=1 and results_valid=1.
  - Drop fc_enable and go to IDLE.
  - sum_result is valid only if run 1 completed.
- Results persist until the next accepted first word in IDLE.
- Memory:
  - Simple dual-port: write from the load path, read from list_rd_addr.
  - Reads are permitted in any state.
  - A read from the address being written in the same cycle returns the old data.
- No arithmetic is performed on deltas. Width is DATA_W end to end, with no sign extension required.

Test Plan:
- Load +1,-2,+3,+1 (in_last on 4th), freq_initial=0, with real frequency_calibrator → list_length=4, sum_result=3, repeat_result=2, results_valid=1, repeat_timeout=0.
- Load +7,+7,-2,-7,-4, freq_initial=0 → sum_result=1, repeat_result=14. Then load +3,+3,+4,-2,-4 → results_valid clears on the first word, then sum_result=4, repeat_result=10.
- Load +1,+1,+1 with TIMEOUT=4096 → sum_result=3, repeat_timeout=1, fc_enable=0, state IDLE within TIMEOUT+2 cycles of REQ2 entry.
- Load 1030 words of +1 with DEPTH=1024 → overflow=1, list_length=1024, in_ready stays 1 until in_last, sum_result=1024.
- Toggle in_valid randomly and hold fc_ready low 50 cycles after the enable is accepted → no word lost or duplicated; fc_enable deasserts the cycle after fc_ready is sampled 0.
- Assert RST_N=0 during WAIT2 → fc_enable=0 and busy=0 immediately; after release, a new load of -1,-2,-3 yields sum_result=-6.

Source files
------------

// File: rtl/calibration_host.sv
// Host-side initiator for frequency_calibrator: loads a delta list into memory,
// runs a single-pass and a repeat-search calibration, and reports both results.
module calibration_host #(
  parameter int DATA_W  = 20,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1048576
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DATA_W-1:0] freq_initial,
  output logic              fc_enable,
  input  logic              fc_ready,
  output logic              fc_re_iterate,
  output logic [DATA_W-1:0] fc_frequency_initial,
  input  logic [DATA_W-1:0] fc_frequency_result,
  input  logic [ADDR_W-1:0] list_rd_addr,
  output logic [DATA_W-1:0] list_rd_data,
  output logic [ADDR_W:0]   list_length,
  output logic [DATA_W-1:0] sum_result,
  output logic [DATA_W-1:0] repeat_result,
  output logic              results_valid,
  output logic              repeat_timeout,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, REQ1, WAIT1, REQ2, WAIT2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   list_length_q, list_length_d;
  logic [DATA_W-1:0] freq_init_q, freq_init_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] repeat_q, repeat_d;
  logic              results_valid_q, results_valid_d;
  logic              repeat_timeout_q, repeat_timeout_d;
  logic              overflow_q, overflow_d;
  logic              fc_enable_q, fc_enable_d;
  logic              fc_re_iterate_q, fc_re_iterate_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] list_rd_data_q;

  logic [DATA_W-1:0] list_mem [DEPTH];

  logic              accept;
  logic              list_full;
  logic              timed_out;
  logic              abort;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  assign accept    = in_valid && in_ready_q;
  assign list_full = (list_length_q == DEPTH_L);
  assign timed_out = (cnt_q == CNT_LAST);
  // The first word of a list always lands at address 0, whatever the old length was.
  assign wr_en     = accept && ((state_q == IDLE) || !list_full);
  assign wr_addr   = (state_q == IDLE) ? '0 : list_length_q[ADDR_W-1:0];

  always_comb begin
    state_d          = state_q;
    list_length_d    = list_length_q;
    freq_init_d      = freq_init_q;
    sum_d            = sum_q;
    repeat_d         = repeat_q;
    results_valid_d  = results_valid_q;
    repeat_timeout_d = repeat_timeout_q;
    overflow_d       = overflow_q;
    fc_enable_d      = fc_enable_q;
    fc_re_iterate_d  = fc_re_iterate_q;
    cnt_d            = cnt_q;
    abort            = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          list_length_d    = (ADDR_W+1)'(1);
          results_valid_d  = 1'b0;
          repeat_timeout_d = 1'b0;
          overflow_d       = 1'b0;
          state_d          = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (list_full) overflow_d = 1'b1;
          else           list_length_d = list_length_q + (ADDR_W+1)'(1);
        end
      end
      REQ1, REQ2: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!fc_ready) begin
          fc_enable_d = 1'b0;
          state_d     = (state_q == REQ1) ? WAIT1 : WAIT2;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      WAIT1: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fc_ready) begin
          sum_d   = fc_frequency_result;
          state_d = REQ2;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      WAIT2: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fc_ready) begin
          repeat_d        = fc_frequency_result;
          results_valid_d = 1'b1;
          fc_re_iterate_d = 1'b0;
          state_d         = IDLE;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && in_last) begin
      freq_init_d = freq_initial;
      state_d     = REQ1;
    end

    if (abort) begin
      repeat_timeout_d = 1'b1;
      results_valid_d  = 1'b1;
      fc_enable_d      = 1'b0;
      fc_re_iterate_d  = 1'b0;
      state_d          = IDLE;
    end

    // Entering a request state restarts the run timer and raises the request.
    if ((state_d != state_q) && ((state_d == REQ1) || (state_d == REQ2))) begin
      cnt_d           = '0;
      fc_enable_d     = 1'b1;
      fc_re_iterate_d = (state_d == REQ2);
    end

    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q          <= IDLE;
      list_length_q    <= '0;
      freq_init_q      <= '0;
      sum_q            <= '0;
      repeat_q         <= '0;
      results_valid_q  <= 1'b0;
      repeat_timeout_q <= 1'b0;
      overflow_q       <= 1'b0;
      fc_enable_q      <= 1'b0;
      fc_re_iterate_q  <= 1'b0;
      in_ready_q       <= 1'b1;
      busy_q           <= 1'b0;
      cnt_q            <= '0;
      list_rd_data_q   <= '0;
    end else begin
      state_q          <= state_d;
      list_length_q    <= list_length_d;
      freq_init_q      <= freq_init_d;
      sum_q            <= sum_d;
      repeat_q         <= repeat_d;
      results_valid_q  <= results_valid_d;
      repeat_timeout_q <= repeat_timeout_d;
      overflow_q       <= overflow_d;
      fc_enable_q      <= fc_enable_d;
      fc_re_iterate_q  <= fc_re_iterate_d;
      in_ready_q       <= in_ready_d;
      busy_q           <= busy_d;
      cnt_q            <= cnt_d;
      list_rd_data_q   <= list_mem[list_rd_addr];
    end
  end

  // List memory has no reset so it maps onto block RAM; same-address reads see old data.
  always_ff @(posedge CLK) begin
    if (wr_en) list_mem[wr_addr] <= in_data;
  end

  assign in_ready             = in_ready_q;
  assign fc_enable            = fc_enable_q;
  assign fc_re_iterate        = fc_re_iterate_q;
  assign fc_frequency_initial = freq_init_q;
  assign list_rd_data         = list_rd_data_q;
  assign list_length          = list_length_q;
  assign sum_result           = sum_q;
  assign repeat_result        = repeat_q;
  assign results_valid        = results_valid_q;
  assign repeat_timeout       = repeat_timeout_q;
  assign overflow             = overflow_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_calibration_host.sv
// Scoreboard bench for calibration_host with a behavioural frequency_calibrator model.
module tb_calibration_host;
  localparam int DATA_W   = 20;
  localparam int DEPTH    = 1024;
  localparam int ADDR_W   = 10;
  localparam int TIMEOUT  = 4096;
  localparam int ITER_CAP = 200000;

  typedef logic [DATA_W-1:0] word_t;
  typedef struct {
    word_t sum;
    word_t rep;
    logic  tmo;
    int    len;
    logic  ovf;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  word_t             in_data = '0;
  logic              in_last = 1'b0;
  word_t             freq_initial = '0;
  logic              fc_enable;
  logic              fc_ready;
  logic              fc_re_iterate;
  word_t             fc_frequency_initial;
  word_t             fc_frequency_result;
  logic [ADDR_W-1:0] list_rd_addr;
  word_t             list_rd_data;
  logic [ADDR_W:0]   list_length;
  word_t             sum_result;
  word_t             repeat_result;
  logic              results_valid;
  logic              repeat_timeout;
  logic              overflow;
  logic              busy;

  always #5 CLK = ~CLK;

  calibration_host #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .freq_initial(freq_initial),
    .fc_enable(fc_enable), .fc_ready(fc_ready), .fc_re_iterate(fc_re_iterate),
    .fc_frequency_initial(fc_frequency_initial), .fc_frequency_result(fc_frequency_result),
    .list_rd_addr(list_rd_addr), .list_rd_data(list_rd_data), .list_length(list_length),
    .sum_result(sum_result), .repeat_result(repeat_result),
    .results_valid(results_valid), .repeat_timeout(repeat_timeout),
    .overflow(overflow), .busy(busy)
  );

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cal_hold = -1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: frequency after one pass over the list.
  function automatic word_t model_sum(input word_t f0, input word_t d[$]);
    word_t f = f0;
    foreach (d[i]) f = f + d[i];
    return f;
  endfunction

  // Reference: first frequency reached twice while cycling the list; 0 if none within the cap.
  function automatic bit model_repeat(input word_t f0, input word_t d[$], output word_t r);
    bit    seen [word_t];
    word_t f = f0;
    r = '0;
    seen[f] = 1'b1;
    for (int it = 0; it < ITER_CAP; it++) begin
      f = f + d[it % d.size()];
      if (seen.exists(f)) begin
        r = f;
        return 1'b1;
      end
      seen[f] = 1'b1;
    end
    return 1'b0;
  endfunction

  // Behavioural calibrator: reads the list back through the DUT memory port.
  initial begin
    word_t cal_buf[$];
    word_t cal_f0;
    word_t res;
    int    cal_len;
    int    idx;
    int    wait_n;
    int    phase;
    bit    mode;
    bit    found;
    phase = 0;
    idx = 0;
    wait_n = 0;
    cal_len = 0;
    mode = 1'b0;
    cal_f0 = '0;
    res = '0;
    fc_ready = 1'b1;
    fc_frequency_result = '0;
    list_rd_addr = '0;
    forever begin
      @(posedge CLK); #1;
      if (!RST_N) begin
        phase = 0;
        fc_ready = 1'b1;
        continue;
      end
      case (phase)
        0: if (fc_enable && fc_ready) begin
          fc_ready = 1'b0;
          mode = fc_re_iterate;
          cal_f0 = fc_frequency_initial;
          cal_len = int'(list_length);
          idx = 0;
          cal_buf.delete();
          phase = 1;
        end
        1: begin
          if (idx == 0) check("enable_drop", 32'(fc_enable), 32'd0);
          if (idx > 0) cal_buf.push_back(list_rd_data);
          if (idx < cal_len) begin
            list_rd_addr = ADDR_W'(idx);
            idx++;
          end else begin
            if (!mode) begin
              res = model_sum(cal_f0, cal_buf);
              found = 1'b1;
            end else begin
              found = model_repeat(cal_f0, cal_buf, res);
            end
            wait_n = (cal_hold >= 0) ? cal_hold : int'($urandom_range(0, 6));
            phase = found ? 2 : 3;
          end
        end
        2: if (wait_n > 0) wait_n--;
           else begin
             fc_frequency_result = res;
             fc_ready = 1'b1;
             phase = 0;
           end
        default: if (!busy) begin
          fc_ready = 1'b1;
          phase = 0;
        end
      endcase
    end
  end

  // Monitor: every rising results_valid retires one expected transaction.
  initial begin
    exp_t e;
    logic rv_prev;
    rv_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (results_valid && !rv_prev) begin
        $display("result len=%0d sum=%0d rep=%0d tmo=%0b ovf=%0b", list_length,
                 $signed(sum_result), $signed(repeat_result), repeat_timeout, overflow);
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("repeat_timeout", 32'(repeat_timeout), 32'(e.tmo));
          check("sum_result", 32'(sum_result), 32'(e.sum));
          if (!e.tmo) check("repeat_result", 32'(repeat_result), 32'(e.rep));
          check("list_length", 32'(list_length), 32'(e.len));
          check("overflow", 32'(overflow), 32'(e.ovf));
          check("fc_enable_done", 32'(fc_enable), 32'd0);
          check("busy_done", 32'(busy), 32'd0);
          check("in_ready_done", 32'(in_ready), 32'd1);
        end
      end
      rv_prev = results_valid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin
      @(posedge CLK); #1;
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic run_list(input word_t d[$], input word_t f0, input int hold);
    exp_t  e;
    word_t stored[$];
    int    eff;
    bit    ready_ok;
    bit    hs;
    int    n;
    wait_idle();
    cal_hold = hold;
    eff = (d.size() > DEPTH) ? DEPTH : d.size();
    stored = d[0:eff-1];
    e.sum = model_sum(f0, stored);
    e.tmo = !model_repeat(f0, stored, e.rep);
    e.len = eff;
    e.ovf = (d.size() > DEPTH);
    sb_q.push_back(e);
    ready_ok = 1'b1;
    foreach (d[i]) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      in_valid = 1'b1;
      in_data = d[i];
      in_last = (i == d.size() - 1);
      freq_initial = in_last ? f0 : word_t'($urandom);
      n = 0;
      hs = 1'b0;
      while (!hs && n < 100) begin
        hs = in_ready;
        if (!hs) ready_ok = 1'b0;
        @(posedge CLK); #1;
        n++;
      end
      if (!hs) check("handshake_timeout", 32'd1, 32'd0);
      if (i == 0) check("rv_clear", 32'(results_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("ready_drop", 32'(in_ready), 32'd0);
    check("ready_during_load", 32'(ready_ok), 32'd1);
  endtask

  initial begin
    word_t d[$];
    int    len;
    int    acc;
    int    n;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fc_enable", 32'(fc_enable), 32'd0);
    check("rst_results_valid", 32'(results_valid), 32'd0);
    check("rst_list_length", 32'(list_length), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_sum", 32'(sum_result), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    d = '{word_t'(1), word_t'(-2), word_t'(3), word_t'(1)};
    run_list(d, word_t'(0), -1);
    d = '{word_t'(7), word_t'(7), word_t'(-2), word_t'(-7), word_t'(-4)};
    run_list(d, word_t'(0), -1);
    d = '{word_t'(3), word_t'(3), word_t'(4), word_t'(-2), word_t'(-4)};
    run_list(d, word_t'(0), -1);
    d = '{word_t'(1), word_t'(1), word_t'(1)};
    run_list(d, word_t'(0), -1);

    d.delete();
    repeat (1030) d.push_back(word_t'(1));
    run_list(d, word_t'(0), -1);

    for (int t = 0; t < 8; t++) begin
      d.delete();
      len = $urandom_range(1, 40);
      acc = 0;
      for (int i = 0; i < len; i++) begin
        d.push_back(word_t'(int'($urandom_range(0, 40)) - 20));
        acc += int'($signed(d[i]));
      end
      if ($urandom_range(0, 1) == 1) d[len-1] = word_t'(int'($signed(d[len-1])) - acc);
      run_list(d, word_t'($urandom), (t == 2) ? 50 : -1);
    end

    d = '{word_t'(5), word_t'(6)};
    run_list(d, word_t'(0), 50);
    n = 0;
    while (!(busy && fc_re_iterate && !fc_enable) && n < 5000) begin
      @(posedge CLK); #1;
      n++;
    end
    check("reach_wait2", 32'(busy && fc_re_iterate && !fc_enable), 32'd1);
    repeat (3) begin @(posedge CLK); #1; end
    #2 RST_N = 1'b0;
    #1;
    check("midrun_fc_enable", 32'(fc_enable), 32'd0);
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_in_ready", 32'(in_ready), 32'd1);
    check("midrun_list_length", 32'(list_length), 32'd0);
    check("midrun_results_valid", 32'(results_valid), 32'd0);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    d = '{word_t'(-1), word_t'(-2), word_t'(-3)};
    run_list(d, word_t'(0), -1);

    n = 0;
    while (sb_q.size() > 0 && n < 20000) begin
      @(posedge CLK); #1;
      n++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
